mem_port_arbiter: RTL

//  Shares the single-ported RAM between instruction fetch and the memory stage's

---
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported RAM between instruction fetch and the data port.
// Data wins by default; a starvation counter forces an instruction grant.
module mem_port_arbiter #(
  parameter int WORD_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              iwait,
  output logic              dwait,
  output logic [WORD_W-1:0] iload,
  output logic [WORD_W-1:0] dload,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  output logic              ramREN,
  output logic              ramWEN
);

  localparam logic [1:0] RAM_ACCESS = 2'b10;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_D = 2'b01,
    GNT_I = 2'b10
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] starve, starve_nxt;
  logic       d_req;
  logic       access;

  assign d_req  = dREN | dWEN;
  assign access = (ramstate == RAM_ACCESS);

  function automatic logic [3:0] starve_inc(input logic [3:0] s);
    return (s >= STARVE_LIM) ? STARVE_LIM : s + 4'd1;
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      starve <= 4'd0;
    end else begin
      state  <= state_nxt;
      starve <= starve_nxt;
    end
  end

  // Grant outputs depend on the live request so a dropped request idles the RAM at once.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve;
    ramaddr    = '0;
    ramstore   = '0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    iwait      = 1'b1;
    dwait      = 1'b1;
    iload      = '0;
    dload      = '0;

    case (state)
      IDLE: begin
        if (d_req && (!iREN || (starve < STARVE_LIM))) begin
          state_nxt = GNT_D;
        end else if (iREN) begin
          state_nxt = GNT_I;
        end
      end

      GNT_D: begin
        if (!d_req) begin
          state_nxt = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          if (access) begin
            dwait      = 1'b0;
            dload      = ramload;
            state_nxt  = IDLE;
            starve_nxt = iREN ? starve_inc(starve) : 4'd0;
          end
        end
      end

      GNT_I: begin
        if (!iREN) begin
          state_nxt = IDLE;
        end else begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (access) begin
            iwait      = 1'b0;
            iload      = ramload;
            state_nxt  = IDLE;
            starve_nxt = 4'd0;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
